led_blink_mode_ctrl: RTL and testbench

Mode controller for the board LED blinker. It takes a push-button and two slide switches and sequences a two-LED blink engine through four modes: off, slow, fast and alternating. Rate, phase, freeze and LED patterns all come from one free-running phase counter. It sits between the raw board I/O pins and the LEDs, and replaces direct switch-to-counter wiring.

---
 rtl/led_ctrl_pkg.sv | 37 +++
 rtl/led_blink_mode_ctrl_input_debounce.sv | 67 ++++++
 rtl/led_blink_mode_ctrl.sv | 103 ++++++++++
 tb/tb_led_blink_mode_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - mode encoding, step base and mapping helpers for the LED blink controller
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_ALT  = 2'b11
  } mode_t;

  localparam int unsigned STEP_BASE = 1;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:  n = MODE_SLOW;
      MODE_SLOW: n = MODE_FAST;
      MODE_FAST: n = MODE_ALT;
      MODE_ALT:  n = MODE_OFF;
      default:   n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] led_map(input mode_t m, input logic tap);
    logic [1:0] l;
    case (m)
      MODE_OFF:  l = 2'b00;
      MODE_SLOW: l = {tap, tap};
      MODE_FAST: l = {tap, tap};
      MODE_ALT:  l = {~tap, tap};
      default:   l = 2'b00;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/led_blink_mode_ctrl_input_debounce.sv
// rtl/led_blink_mode_ctrl_input_debounce.sv - 2-flop synchroniser, optional debounce filter and rising-edge pulse
// Build option: LED_CTRL_DEBOUNCE_EN enables the stability-window filter after the synchroniser.
module input_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Windows shorter than two cycles cannot be expressed by the filter counter
  if (DB_CYCLES < 2) begin : g_db_cycles_below_min
  end

`ifdef LED_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/led_blink_mode_ctrl.sv
// rtl/led_blink_mode_ctrl.sv - push-button mode FSM, phase counter and LED mapping for a two-LED blinker
// Build option: define LED_CTRL_DEBOUNCE_EN to debounce btn over DB_CYCLES clocks.
module led_blink_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CNT_W     = 26,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] sw,
  output logic [1:0] led,
  output logic [1:0] mode
);

  logic [1:0]       sw_sync1;
  logic [1:0]       sw_sync2;
  logic             press;
  mode_t            mode_q;
  mode_t            mode_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] step;
  logic [1:0]       led_q;
  logic [1:0]       led_n;

  input_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn),
    .press (press)
  );

  // Switches are level controls, so synchronising them is enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1 <= 2'b00;
      sw_sync2 <= 2'b00;
    end else begin
      sw_sync1 <= sw;
      sw_sync2 <= sw_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_n;
    end
  end

  always_comb begin
    mode_n = mode_q;
    if (press) begin
      mode_n = next_mode(mode_q);
    end
  end

  always_comb begin
    step = CNT_W'(STEP_BASE) << sw_sync2[0];
    if (mode_q == MODE_FAST) begin
      step = step << 1;
    end
  end

  // A press restarts the blink phase, overriding freeze and step
  always_comb begin
    cnt_n = cnt + step;
    if (press) begin
      cnt_n = '0;
    end else if (sw_sync2[1]) begin
      cnt_n = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end

  always_comb begin
    led_n = led_map(mode_q, cnt[CNT_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 2'b00;
    end else begin
      led_q <= led_n;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_blink_mode_ctrl.sv
// tb/tb_led_blink_mode_ctrl.sv - scoreboard bench for led_blink_mode_ctrl (CNT_W=4, DB_CYCLES=4)
module tb_led_blink_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] sw  = 2'b00;
  logic [1:0] led;
  logic [1:0] mode;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         at;
    logic [1:0] mode;
    logic [1:0] led;
    bit         use_led;
    logic [3:0] cnt;
    bit         use_cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  led_blink_mode_ctrl #(
    .CNT_W     (4),
    .DB_CYCLES (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .led  (led),
    .mode (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input exp_t e);
    n_checks++;
    if (mode !== e.mode || (e.use_led && led !== e.led) || (e.use_cnt && dut.cnt !== e.cnt)) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got mode=%b led=%b cnt=%0d, expected mode=%b led=%b(chk %0d) cnt=%0d(chk %0d)",
               e.name, cyc, mode, led, dut.cnt, e.mode, e.led, e.use_led, e.cnt, e.use_cnt);
    end
  endtask

  task automatic expect_at(input int at, input logic [1:0] m, input logic [1:0] l, input bit ul,
                           input logic [3:0] c, input bit uc, input string nm);
    exp_t e;
    e.at = at; e.mode = m; e.led = l; e.use_led = ul; e.cnt = c; e.use_cnt = uc; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: state after edge `at` is sampled on the following falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at >= 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: sample slot %0d missed (now %0d)", e.name, e.at, cyc);
      end else begin
        compare(e);
      end
    end
  end

  // Asynchronous reset items are checked shortly after rst rises, before any clock edge
  always @(posedge rst) begin
    #1;
    while (sb.size() > 0 && sb[0].at < 0) compare(sb.pop_front());
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(output int n);
    n = cyc + 1;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: expectation never sampled", e.name);
    end
  endtask

  initial begin
    int t, n, n2, n3, n4, m, r;
    expect_at(-1, 2'b00, 2'b00, 1, 4'd0, 1, "reset_init");
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t = cyc;
    expect_at(t + 2, 2'b00, 2'b00, 1, 4'd0, 0, "idle_off");
    wait_cyc(t + 4);

`ifdef LED_CTRL_DEBOUNCE_EN
    t = cyc + 1;
    expect_at(t + 6,  2'b00, 2'b00, 1, 4'd0, 0, "glitch_ignored_a");
    expect_at(t + 12, 2'b00, 2'b00, 1, 4'd0, 0, "glitch_ignored_b");
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    wait_cyc(t + 14);
    n = cyc + 1;
    expect_at(n + 5,  2'b00, 2'b00, 0, 4'd0, 0, "hold_before_level");
    expect_at(n + 6,  2'b01, 2'b00, 0, 4'd0, 1, "hold_advance");
    expect_at(n + 7,  2'b01, 2'b00, 1, 4'd1, 1, "hold_led_off_phase");
    expect_at(n + 30, 2'b01, 2'b00, 0, 4'd0, 0, "hold_release_no_event");
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    wait_cyc(n + 32);
    n = cyc + 1;
    expect_at(n + 5, 2'b01, 2'b00, 0, 4'd0, 0, "window_edge_before");
    expect_at(n + 6, 2'b10, 2'b00, 0, 4'd0, 1, "window_edge_advance");
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    wait_cyc(n + 8);
`else
    // SLOW, sw=00: step 1, led high for counter 8..15
    press(n);
    expect_at(n + 1,  2'b00, 2'b00, 1, 4'd0, 0, "slow_pre");
    expect_at(n + 2,  2'b01, 2'b00, 1, 4'd0, 1, "slow_mode");
    expect_at(n + 3,  2'b01, 2'b00, 1, 4'd1, 1, "slow_led_n3");
    expect_at(n + 10, 2'b01, 2'b00, 1, 4'd8, 1, "slow_before_tap");
    expect_at(n + 11, 2'b01, 2'b11, 1, 4'd9, 1, "slow_tap_on");
    expect_at(n + 18, 2'b01, 2'b11, 1, 4'd0, 1, "slow_wrap");
    expect_at(n + 19, 2'b01, 2'b00, 1, 4'd1, 1, "slow_tap_off");
    wait_cyc(n + 19);
    sw = 2'b01;
    wait_cyc(n + 21);

    // FAST with sw[0]=1: step 4
    press(n2);
    expect_at(n2 + 1, 2'b01, 2'b00, 0, 4'd0, 0, "fast_pre");
    expect_at(n2 + 2, 2'b10, 2'b00, 0, 4'd0, 1, "fast_mode");
    expect_at(n2 + 3, 2'b10, 2'b00, 1, 4'd4, 1, "fast_c4");
    expect_at(n2 + 4, 2'b10, 2'b00, 1, 4'd8, 1, "fast_c8");
    expect_at(n2 + 5, 2'b10, 2'b11, 1, 4'd12, 1, "fast_on");
    expect_at(n2 + 7, 2'b10, 2'b00, 1, 4'd4, 1, "fast_off");
    expect_at(n2 + 9, 2'b10, 2'b11, 1, 4'd12, 1, "fast_on2");
    wait_cyc(n2 + 9);
    sw = 2'b11;
    expect_at(n2 + 10, 2'b10, 2'b11, 1, 4'd0, 1, "freeze_sync_a");
    expect_at(n2 + 11, 2'b10, 2'b00, 1, 4'd4, 1, "freeze_sync_b");
    expect_at(n2 + 14, 2'b10, 2'b00, 1, 4'd4, 1, "freeze_hold_a");
    expect_at(n2 + 18, 2'b10, 2'b00, 1, 4'd4, 1, "freeze_hold_b");
    wait_cyc(n2 + 18);
    sw = 2'b00;
    wait_cyc(n2 + 21);

    // ALT, sw=00: step 1, complementary LEDs
    press(n3);
    expect_at(n3 + 1,  2'b10, 2'b00, 0, 4'd0, 0, "alt_pre");
    expect_at(n3 + 2,  2'b11, 2'b00, 0, 4'd0, 1, "alt_mode");
    expect_at(n3 + 3,  2'b11, 2'b10, 1, 4'd1, 1, "alt_phase0");
    expect_at(n3 + 10, 2'b11, 2'b10, 1, 4'd8, 1, "alt_phase0_end");
    expect_at(n3 + 11, 2'b11, 2'b01, 1, 4'd9, 1, "alt_phase1");
    expect_at(n3 + 17, 2'b11, 2'b01, 1, 4'd15, 1, "alt_cnt15");
    wait_cyc(n3 + 15);

    // Press lands on the edge where the counter holds 15
    press(n4);
    expect_at(n4 + 2, 2'b00, 2'b01, 1, 4'd0, 1, "wrap_press_off");
    expect_at(n4 + 3, 2'b00, 2'b00, 1, 4'd1, 1, "wrap_led_off");
    wait_cyc(n4 + 5);

    press(m);
    expect_at(m + 2, 2'b01, 2'b00, 0, 4'd0, 1, "cycle_slow");
    wait_cyc(m + 4);
    press(m);
    expect_at(m + 2, 2'b10, 2'b00, 0, 4'd0, 1, "cycle_fast");
    wait_cyc(m + 4);
    press(m);
    expect_at(m + 2, 2'b11, 2'b00, 0, 4'd0, 1, "cycle_alt");
    wait_cyc(m + 7);

    // Reset mid-ALT, with btn held through reset release
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    expect_at(-1, 2'b00, 2'b00, 1, 4'd0, 1, "reset_mid_alt");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    expect_at(r + 2,  2'b00, 2'b00, 1, 4'd0, 0, "held_pre");
    expect_at(r + 3,  2'b01, 2'b00, 1, 4'd0, 1, "held_one_press");
    expect_at(r + 12, 2'b01, 2'b00, 0, 4'd0, 0, "held_no_repeat");
    wait_cyc(r + 12);
    btn = 1'b0;
    expect_at(r + 20, 2'b01, 2'b00, 0, 4'd0, 0, "release_no_event");
    wait_cyc(r + 21);
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
